spi_aes_host: RTL and testbench

- SPI controller for the SPI AES target. It is the host end of the interface the target exposes.
- Accepts one 128-bit block from a system-side valid/ready interface.
- Shifts the block into the target, pulses START, and free-runs SCK while the target computes (the target's AES core is clocked by SCK).
- Waits for BUSY to fall, reads the 128-bit result back over MISO, and presents it with a done pulse. Sits in the programmer/test FPGA between host logic and the target pins.

---
 rtl/spi_aes_host.sv | 201 ++++++++++++++++++++
 tb/tb_spi_aes_host.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_aes_host.sv
// ---------------------------------------------------------------------------
// spi_aes_host
// Host-side SPI controller for the SPI AES target. Takes one WIDTH-bit block
// over a valid/ready interface, shifts it into the target (LOAD), pulses
// START for one SCK pulse, free-runs SCK while the target computes (its core
// is clocked by SCK), waits for BUSY to fall, lets the target load its result,
// reads the result back (READ) and presents it with a one-clk out_valid.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   in_valid/in_ready   block handshake; in_ready is high only in IDLE
//   in_data             plaintext block
//   out_valid/out_data  one-clk result pulse; out_data held until next pulse
//   err                 one-clk pulse when the target never finishes
//   sck/mosi/miso/cs_n  SPI pins (sck idles low, cs_n active low)
//   start/busy_in       target START output and BUSY input
// ---------------------------------------------------------------------------
module spi_aes_host #(
    parameter int unsigned WIDTH       = 128,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned MISO_LAT    = 1,
    parameter int unsigned LOAD_PULSES = 1,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             err,
    output logic             sck,
    output logic             mosi,
    input  logic             miso,
    output logic             cs_n,
    output logic             start,
    input  logic             busy_in
);

    localparam int unsigned N  = WIDTH + MISO_LAT;
    localparam int unsigned BW = $clog2(N + 1);
    localparam int unsigned DW = $clog2(CLK_DIV + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(N);
    localparam logic [BW-1:0] DRAIN_END = BW'(LOAD_PULSES);
    localparam logic [DW-1:0] DIV_END   = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TO_END    = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_READ
    } state_t;

    state_t           state_q;
    logic [DW-1:0]    div_q;
    logic [BW-1:0]    bit_q;
    logic [TW-1:0]    to_q;
    logic [N-1:0]     tx_q;
    logic [WIDTH-1:0] rx_q;
    logic             seen_busy_q;
    logic             drain_q;
    logic             sck_q;
    logic             cs_n_q;
    logic             start_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             err_q;

    logic [DW-1:0] div_d;
    logic [BW-1:0] bit_d;
    logic [TW-1:0] to_d;
    logic          phase_end;
    logic          framed;

    assign div_d     = div_q + DW'(1);
    assign bit_d     = bit_q + BW'(1);
    assign to_d      = to_q + TW'(1);
    assign phase_end = (div_q == DIV_END);
    assign framed    = (state_q == S_LOAD) || (state_q == S_READ);

    // mosi is the MSB of the transmit shifter; the shifter only moves at
    // falling instants, so mosi is stable across every rising edge.
    assign mosi      = tx_q[N-1];
    assign sck       = sck_q;
    assign cs_n      = cs_n_q;
    assign start     = start_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            to_q        <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            seen_busy_q <= 1'b0;
            drain_q     <= 1'b0;
            sck_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            start_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            if (state_q == S_IDLE) begin
                if (in_valid) begin
                    // Zero-extension places the MISO_LAT pad bits ahead of the MSB.
                    tx_q       <= N'(in_data);
                    state_q    <= S_LOAD;
                    in_ready_q <= 1'b0;
                    cs_n_q     <= 1'b0;
                    div_q      <= '0;
                    bit_q      <= '0;
                end
            end else begin
                div_q <= phase_end ? '0 : div_d;
                if (phase_end) begin
                    if (!sck_q) begin
                        // End of a low phase: either rise, or close the frame
                        // once the low phase after the last fall has elapsed.
                        if (framed && bit_q == BIT_LAST) begin
                            cs_n_q <= 1'b1;
                            tx_q   <= '0;
                            if (state_q == S_LOAD) begin
                                state_q <= S_START;
                                start_q <= 1'b1;
                            end else begin
                                state_q     <= S_IDLE;
                                in_ready_q  <= 1'b1;
                                out_data_q  <= rx_q;
                                out_valid_q <= 1'b1;
                            end
                        end else begin
                            sck_q <= 1'b1;
                        end
                    end else begin
                        // Falling instant: all target-driven inputs sampled here.
                        sck_q <= 1'b0;
                        if (framed) begin
                            bit_q <= bit_d;
                            rx_q  <= {rx_q[WIDTH-2:0], miso};
                            tx_q  <= tx_q << 1;
                        end else if (state_q == S_START) begin
                            start_q     <= 1'b0;
                            state_q     <= S_WAIT;
                            to_q        <= TW'(1);
                            bit_q       <= '0;
                            seen_busy_q <= 1'b0;
                            drain_q     <= 1'b0;
                        end else begin
                            // WAIT: drain pulses after BUSY fell take priority
                            // over the timeout, which stops counting once
                            // completion has been observed.
                            if (drain_q) begin
                                if (bit_d == DRAIN_END) begin
                                    state_q <= S_READ;
                                    cs_n_q  <= 1'b0;
                                    bit_q   <= '0;
                                    drain_q <= 1'b0;
                                end else begin
                                    bit_q <= bit_d;
                                end
                            end else if (seen_busy_q && !busy_in) begin
                                if (LOAD_PULSES == 0) begin
                                    state_q <= S_READ;
                                    cs_n_q  <= 1'b0;
                                    bit_q   <= '0;
                                end else begin
                                    drain_q <= 1'b1;
                                end
                            end else if (to_d == TO_END) begin
                                err_q      <= 1'b1;
                                state_q    <= S_IDLE;
                                in_ready_q <= 1'b1;
                            end else begin
                                to_q <= to_d;
                                if (busy_in) begin
                                    seen_busy_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_aes_host.sv
module tb_spi_aes_host;

    localparam logic [127:0] X1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R1 = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] X2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] R2 = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] X3 = 128'h80000000000000000000000000000001;
    localparam logic [127:0] R3 = 128'h7ffffffffffffffffffffffffffffffe;
    localparam logic [127:0] X4 = 128'h13579bdf2468ace013579bdf2468ace0;
    localparam logic [127:0] X5 = 128'hdeadbeefcafef00d0123456789abcdef;
    localparam logic [127:0] R5 = 128'h2152411035010ff2fedcba9876543210;
    localparam logic [127:0] X6 = 128'hffffffff00000000aaaaaaaa55555555;
    localparam logic [127:0] R6 = 128'h00000000ffffffff55555555aaaaaaaa;
    localparam logic [127:0] X7 = 128'h11111111222222223333333344444444;

    localparam int W_OV_A    = 0;
    localparam int W_CSHI_A  = 1;
    localparam int W_NSTRT_A = 2;
    localparam int W_SCK_A   = 3;
    localparam int W_NSCK_A  = 4;
    localparam int W_ERR_B   = 5;
    localparam int W_CSHI_B  = 6;
    localparam int W_SCK_B   = 7;
    localparam int W_NSCK_B  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic         in_valid_a = 1'b0, in_ready_a, out_valid_a, err_a;
    logic [127:0] in_data_a = '0, out_data_a;
    logic         sck_a, mosi_a, cs_n_a, start_a;
    logic         miso_a, busy_a;

    logic         in_valid_b = 1'b0, in_ready_b, out_valid_b, err_b;
    logic [127:0] in_data_b = '0, out_data_b;
    logic         sck_b, mosi_b, cs_n_b, start_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_aes_host #(
        .WIDTH(128), .CLK_DIV(4), .MISO_LAT(1), .LOAD_PULSES(1), .TIMEOUT(4096)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .err(err_a),
        .sck(sck_a), .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a),
        .start(start_a), .busy_in(busy_a)
    );

    spi_aes_host #(
        .WIDTH(128), .CLK_DIV(1), .MISO_LAT(1), .LOAD_PULSES(1), .TIMEOUT(40)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .err(err_b),
        .sck(sck_b), .mosi(mosi_b), .miso(1'b0), .cs_n(cs_n_b),
        .start(start_b), .busy_in(1'b0)
    );

    // Target model: 128-bit input shifter, result = bitwise inverse of the
    // loaded block, BUSY high for 11 pulses starting at the START pulse, result
    // loaded on the first pulse after BUSY falls, one pulse of MISO latency.
    logic [127:0] t_sr = '0, t_out = '0, t_res = '0;
    logic         t_pipe = 1'b0, t_miso = 1'b0, t_busy = 1'b0, t_pend = 1'b0;
    int           t_cnt = 0;
    assign miso_a = t_miso;
    assign busy_a = t_busy;

    always @(posedge sck_a) begin
        if (!cs_n_a) begin
            t_sr   <= {t_sr[126:0], mosi_a};
            t_pipe <= t_out[127];
            t_miso <= t_pipe;
            t_out  <= {t_out[126:0], 1'b0};
        end else if (start_a) begin
            t_res  <= ~t_sr;
            t_busy <= 1'b1;
            t_cnt  <= 11;
            t_pend <= 1'b1;
        end else if (t_busy) begin
            if (t_cnt == 1) t_busy <= 1'b0;
            t_cnt <= t_cnt - 1;
        end else if (t_pend) begin
            t_out  <= t_res;
            t_pend <= 1'b0;
        end
    end

    int fr_pulses_a = 0, start_pulses_a = 0, start_bad_a = 0, ov_cnt_a = 0;
    int wp_b = 0, start_pulses_b = 0, start_bad_b = 0, ov_cnt_b = 0;

    always @(posedge sck_a) begin
        if (!cs_n_a) fr_pulses_a++;
        if (start_a) begin
            start_pulses_a++;
            if (!cs_n_a) start_bad_a++;
        end
    end

    always @(posedge sck_b) begin
        if (cs_n_b) wp_b++;
        if (start_b) begin
            start_pulses_b++;
            if (!cs_n_b) start_bad_b++;
        end
    end

    always @(negedge clk) begin
        if (out_valid_a) ov_cnt_a++;
        if (out_valid_b) ov_cnt_b++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            W_OV_A:    return out_valid_a;
            W_CSHI_A:  return cs_n_a;
            W_NSTRT_A: return !start_a;
            W_SCK_A:   return sck_a;
            W_NSCK_A:  return !sck_a;
            W_ERR_B:   return err_b;
            W_CSHI_B:  return cs_n_b;
            W_SCK_B:   return sck_b;
            W_NSCK_B:  return !sck_b;
            default:   return 1'b0;
        endcase
    endfunction

    // Returns on the first negedge where the selected condition holds.
    task automatic wait_for(input int w, input int budget, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sig(w)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk({tag, "_wait"}, {127'd0, found}, 128'd1);
    endtask

    task automatic count_while(input int w, output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (!sig(w)) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send_a(input logic [127:0] d);
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = d;
        @(negedge clk);
        in_valid_a = 1'b0;
    endtask

    int base, hi, lo, ov0, ovs;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl_a", {121'd0, sck_a, cs_n_a, mosi_a, start_a, in_ready_a, out_valid_a, err_a},
            {121'd0, 7'b0100100});
        chk("reset_data_a", out_data_a, '0);
        chk("reset_ctrl_b", {123'd0, sck_b, cs_n_b, start_b, in_ready_b, err_b}, {123'd0, 5'b01010});
        @(negedge clk);
        rst = 1'b0;

        // Block 1 on the CLK_DIV=4 instance with the target model.
        base = fr_pulses_a;
        send_a(X1);
        chk("ready_drop_a", {127'd0, in_ready_a}, 128'd0);
        chk("cs_low_a", {127'd0, cs_n_a}, 128'd0);
        wait_for(W_SCK_A, 20, "first_rise_a");
        count_while(W_SCK_A, hi);
        count_while(W_NSCK_A, lo);
        chk("sck_high_cycles_a", 128'(hi), 128'd4);
        chk("sck_low_cycles_a", 128'(lo), 128'd4);
        wait_for(W_CSHI_A, 3000, "load_end_a");
        chk("load_pulses_a", 128'(fr_pulses_a - base), 128'd129);
        chk("target_reg_a", t_sr, X1);
        chk("start_set_a", {127'd0, start_a}, 128'd1);
        wait_for(W_OV_A, 6000, "ov1_a");
        chk("result1_a", out_data_a, R1);
        chk("ready_back_a", {127'd0, in_ready_a}, 128'd1);
        @(negedge clk);
        chk("ov_pulse_a", {127'd0, out_valid_a}, 128'd0);
        chk("ov_count1_a", 128'(ov_cnt_a), 128'd1);
        chk("frame_pulses_a", 128'(fr_pulses_a - base), 128'd258);
        chk("start_pulses_a", 128'(start_pulses_a), 128'd1);
        chk("start_cs_a", 128'(start_bad_a), 128'd0);

        // CLK_DIV=1 instance: busy tied low, so only the timeout can end WAIT.
        @(negedge clk);
        in_valid_b = 1'b1;
        in_data_b  = X1;
        @(negedge clk);
        in_valid_b = 1'b0;
        wait_for(W_SCK_B, 10, "first_rise_b");
        count_while(W_SCK_B, hi);
        count_while(W_NSCK_B, lo);
        chk("sck_high_cycles_b", 128'(hi), 128'd1);
        chk("sck_low_cycles_b", 128'(lo), 128'd1);
        wait_for(W_CSHI_B, 1000, "load_end_b");
        wait_for(W_ERR_B, 500, "err_b");
        chk("timeout_pulses_b", 128'(wp_b), 128'd40);
        chk("timeout_ready_b", {127'd0, in_ready_b}, 128'd1);
        chk("start_pulses_b", 128'(start_pulses_b), 128'd1);
        chk("start_cs_b", 128'(start_bad_b), 128'd0);
        @(negedge clk);
        chk("err_pulse_b", {127'd0, err_b}, 128'd0);
        chk("timeout_data_b", out_data_b, '0);
        repeat (20) @(negedge clk);
        chk("timeout_no_ov_b", 128'(ov_cnt_b), 128'd0);

        // Back-to-back blocks with in_valid held; data changes after the first latch.
        ov0 = ov_cnt_a;
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = X2;
        @(negedge clk);
        in_data_a  = X3;
        chk("b2b_busy_a", {127'd0, in_ready_a}, 128'd0);
        wait_for(W_OV_A, 6000, "b2b_ov1_a");
        chk("b2b_result1_a", out_data_a, R2);
        @(negedge clk);
        chk("b2b_relatch_a", {127'd0, in_ready_a}, 128'd0);
        in_valid_a = 1'b0;
        wait_for(W_OV_A, 6000, "b2b_ov2_a");
        chk("b2b_result2_a", out_data_a, R3);
        @(negedge clk);
        chk("b2b_ov_count_a", 128'(ov_cnt_a - ov0), 128'd2);

        // Reset in the middle of LOAD after 60 pulses.
        base = fr_pulses_a;
        send_a(X4);
        for (int i = 0; i < 2000; i++) begin
            if (fr_pulses_a - base >= 60) break;
            @(negedge clk);
        end
        chk("mid_load_bits_a", 128'(fr_pulses_a - base), 128'd60);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ctrl_a", {124'd0, cs_n_a, sck_a, start_a, in_ready_a}, {124'd0, 4'b1001});
        chk("mid_rst_data_a", out_data_a, '0);
        @(negedge clk);
        rst = 1'b0;
        send_a(X5);
        wait_for(W_OV_A, 6000, "after_rst_ov_a");
        chk("after_rst_result_a", out_data_a, R5);

        // in_valid pulsed during WAIT must be ignored.
        send_a(X6);
        wait_for(W_CSHI_A, 3000, "wait_load_end_a");
        wait_for(W_NSTRT_A, 100, "wait_enter_a");
        repeat (5) @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = X7;
        @(negedge clk);
        in_valid_a = 1'b0;
        chk("wait_ignore_ready_a", {127'd0, in_ready_a}, 128'd0);
        wait_for(W_OV_A, 6000, "wait_ov_a");
        chk("wait_ignore_result_a", out_data_a, R6);
        @(negedge clk);
        ovs = ov_cnt_a;
        repeat (300) @(negedge clk);
        chk("idle_after_a", {126'd0, in_ready_a, cs_n_a}, {126'd0, 2'b11});
        chk("no_extra_ov_a", 128'(ov_cnt_a - ovs), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

endmodule
